// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store unit:
//   - lsu_state_e   : FSM states of the load/store sequencer
//   - F3_*          : funct3 encodings for access size and sign
//   - access_illegal / access_misaligned : request qualification helpers
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // A simultaneous load+store, a store with an unsigned or undefined size,
    // or a load with an undefined size cannot be executed.
    function automatic logic access_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [2:0] f3);
        logic bad;
        bad = rd & wr;
        if (wr && !(f3 == F3_B || f3 == F3_H || f3 == F3_W)) begin
            bad = 1'b1;
        end
        if (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic access_misaligned(input logic [2:0] f3,
                                               input logic [1:0] off);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Data-memory request/response bus between the load/store unit and memory.
//   dmem_req    : request valid, held until dmem_gnt
//   dmem_we     : 1 = write, 0 = read
//   dmem_addr   : word-aligned byte address
//   dmem_wdata  : store data, already lane-replicated
//   dmem_be     : byte enables (all ones for reads)
//   dmem_gnt    : memory accepts the request this cycle
//   dmem_rvalid : read data valid (earliest the cycle after dmem_gnt)
//   dmem_rdata  : raw read word
// Modports: master = load/store unit side, slave = memory side.
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int D_WIDTH = 32
);
    logic               dmem_req;
    logic               dmem_we;
    logic [D_WIDTH-1:0] dmem_addr;
    logic [D_WIDTH-1:0] dmem_wdata;
    logic [3:0]         dmem_be;
    logic               dmem_gnt;
    logic               dmem_rvalid;
    logic [D_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load formatter: picks the addressed byte/half lane out of a
// raw memory word and sign- or zero-extends it according to funct3.
//   funct3_i   : access size/sign (B, H, W, BU, HU)
//   byte_off_i : address bits [1:0] of the access
//   word_i     : raw word returned by memory
//   data_o     : extended load result
// ----------------------------------------------------------------------------
module load_extend
    import riscv_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         byte_off_i,
    input  logic [D_WIDTH-1:0] word_i,
    output logic [D_WIDTH-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every variable written here gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        byte_lane = 8'(word_i >> {byte_off_i, 3'b000});
        // The half lane is chosen by address bit 1 only; bit 0 is known to be
        // zero for any halfword access that got past the alignment check.
        half_lane = 16'(word_i >> {byte_off_i[1], 4'b0000});
        data_o    = word_i;

        case (funct3_i)
            F3_B:    data_o = {{(D_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_H:    data_o = {{(D_WIDTH-16){half_lane[15]}}, half_lane};
            F3_BU:   data_o = {{(D_WIDTH-8){1'b0}}, byte_lane};
            F3_HU:   data_o = {{(D_WIDTH-16){1'b0}}, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Sequences one execute-stage load or store onto a simple req/gnt/rvalid
// data-memory bus, stalling the pipeline while the access is in flight.
//   clk, rst_n           : clock, asynchronous active-low reset
//   memread, memwrite    : execute-stage instruction is a load / store
//   funct3               : access size and sign
//   aluout               : effective byte address
//   regop2               : store data
//   stall                : hold PC and upstream stages
//   rdata, rdata_valid   : extended load result and its one-cycle strobe
//   fault                : misaligned or illegal access rejected (IDLE only)
//   dmem                 : data-memory bus (master side)
// Flow: IDLE -accept-> REQ -gnt-> (store) RESP / (load) WAIT -rvalid-> RESP
//       -> IDLE. A request present while in RESP is not taken; the pipeline
//       advances in that cycle because stall is low.
// ----------------------------------------------------------------------------
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] aluout,
    input  logic [D_WIDTH-1:0] regop2,
    output logic               stall,
    output logic [D_WIDTH-1:0] rdata,
    output logic               rdata_valid,
    output logic               fault,
    load_store_unit_if.master  dmem
);

    lsu_state_e         state_q;
    logic [D_WIDTH-1:0] addr_q;
    logic [2:0]         funct3_q;
    logic               we_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic [3:0]         be_q;
    logic               req_q;
    logic [D_WIDTH-1:0] rdata_q;
    logic               rdata_valid_q;

    logic [D_WIDTH-1:0] wdata_d;
    logic [3:0]         be_d;
    logic [D_WIDTH-1:0] load_ext;

    logic mem_access;
    logic bad_access;
    logic idle_live;
    logic accept;

    // ------------------------------------------------------------------
    // Request qualification. fault and the IDLE part of stall are
    // combinational so the pipeline reacts in the same cycle; both are
    // gated by rst_n so they read low while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        mem_access = memread | memwrite;
        bad_access = access_illegal(memread, memwrite, funct3)
                   | access_misaligned(funct3, aluout[1:0]);
        idle_live  = rst_n && (state_q == IDLE) && mem_access;
        accept     = idle_live && !bad_access;
    end

    assign fault = idle_live && bad_access;
    assign stall = accept || (state_q == REQ) || (state_q == WAIT);

    // ------------------------------------------------------------------
    // Store formatting: data is replicated across all lanes and the byte
    // enables select the addressed lane(s). Loads read the whole word.
    // ------------------------------------------------------------------
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (memwrite) begin
            case (funct3)
                F3_B: begin
                    be_d    = 4'b0001 << aluout[1:0];
                    wdata_d = {(D_WIDTH/8){regop2[7:0]}};
                end
                F3_H: begin
                    be_d    = 4'b0011 << {aluout[1], 1'b0};
                    wdata_d = {(D_WIDTH/16){regop2[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = regop2;
                end
            endcase
        end
    end

    load_extend #(
        .D_WIDTH (D_WIDTH)
    ) u_load_extend (
        .funct3_i   (funct3_q),
        .byte_off_i (addr_q[1:0]),
        .word_i     (dmem.dmem_rdata),
        .data_o     (load_ext)
    );

    // ------------------------------------------------------------------
    // Sequencer. Bus request and rdata_valid are registered so they are
    // glitch-free and stable for the whole cycle.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched request payload is reset along with the FSM
            // so an abandoned transaction leaves nothing behind on the bus.
            state_q       <= IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            be_q          <= '0;
            req_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdata_valid_q <= 1'b0;
                    if (accept) begin
                        addr_q   <= aluout;
                        funct3_q <= funct3;
                        we_q     <= memwrite;
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                        req_q    <= 1'b1;
                        state_q  <= REQ;
                    end
                end

                REQ: begin
                    if (dmem.dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? RESP : WAIT;
                    end
                end

                WAIT: begin
                    if (dmem.dmem_rvalid) begin
                        rdata_q       <= load_ext;
                        rdata_valid_q <= 1'b1;
                        state_q       <= RESP;
                    end
                end

                RESP: begin
                    rdata_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end

                default: begin
                    req_q         <= 1'b0;
                    rdata_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {addr_q[D_WIDTH-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit. Expected load results are pushed
// into a scoreboard queue when a load is issued and popped when rdata_valid
// is seen. Each scenario task drives its own stimulus and checks inline.
// ----------------------------------------------------------------------------
module tb_load_store_unit;
    import riscv_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          memread;
    logic          memwrite;
    logic [2:0]    funct3;
    logic [DW-1:0] aluout;
    logic [DW-1:0] regop2;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          fault;

    load_store_unit_if #(.D_WIDTH(DW)) dmem ();

    load_store_unit #(.D_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .memread     (memread),
        .memwrite    (memwrite),
        .funct3      (funct3),
        .aluout      (aluout),
        .regop2      (regop2),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .fault       (fault),
        .dmem        (dmem)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_load;

    // Observations from the most recent do_access call.
    int            obs_stall;
    int            obs_req;
    int            obs_rvalid;
    int            obs_fault;
    bit            obs_fault_first;
    bit            obs_payload_stable;
    bit            obs_post_quiet;
    logic          obs_we;
    logic [DW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata;
    logic [3:0]    obs_be;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [DW-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        int          hi;
        b  = w[8*int'(off) +: 8];
        hi = off[1] ? 16 : 0;
        h  = w[hi +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'b000) begin
            case (off)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (f3 == 3'b001) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [DW-1:0] model_wdata(input logic [2:0] f3, input logic [DW-1:0] d);
        if (f3 == 3'b000) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3 == 3'b001) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // ---------------- transaction driver / memory responder ----------------
    // Drives one request, holds it while stall is high (as the pipeline does),
    // answers with gnt after gnt_wait REQ cycles and rvalid rv_wait cycles
    // after the grant cycle. Ends one idle cycle after stall drops.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                             input int gnt_wait, input int rv_wait,
                             input logic [DW-1:0] mem_word);
        int  req_seen  = 0;
        int  wait_seen = 0;
        bit  granted   = 0;
        bit  rv_given  = 0;
        bit  done      = 0;
        logic [DW-1:0] exp;
        obs_stall = 0; obs_req = 0; obs_rvalid = 0; obs_fault = 0;
        obs_fault_first = 0; obs_payload_stable = 1; obs_post_quiet = 0;
        obs_we = 0; obs_addr = '0; obs_wdata = '0; obs_be = '0;

        @(posedge clk); #1;
        memread = rd; memwrite = wr; funct3 = f3; aluout = addr; regop2 = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
            end
            dmem.dmem_gnt    = 1'b0;
            dmem.dmem_rvalid = 1'b0;
            dmem.dmem_rdata  = 32'hDEAD_BEEF;
            if (dmem.dmem_req) begin
                if (req_seen == gnt_wait) begin
                    dmem.dmem_gnt = 1'b1;
                    granted = 1;
                end
                req_seen++;
            end else if (granted && rd && !rv_given) begin
                if (wait_seen == rv_wait) begin
                    dmem.dmem_rvalid = 1'b1;
                    dmem.dmem_rdata  = mem_word;
                    rv_given = 1;
                end
                wait_seen++;
            end
            #1;
            if (c == 0) obs_fault_first = fault;
            if (stall) obs_stall++;
            if (fault) obs_fault++;
            if (dmem.dmem_req) begin
                if (obs_req == 0) begin
                    obs_we = dmem.dmem_we; obs_addr = dmem.dmem_addr;
                    obs_wdata = dmem.dmem_wdata; obs_be = dmem.dmem_be;
                end else if (dmem.dmem_we !== obs_we || dmem.dmem_addr !== obs_addr ||
                             dmem.dmem_wdata !== obs_wdata || dmem.dmem_be !== obs_be) begin
                    obs_payload_stable = 0;
                end
                obs_req++;
            end
            if (rdata_valid) begin
                obs_rvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: rdata_valid with rdata=%h, no load expected", rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (rdata !== exp) begin
                        errors++;
                        $display("FAIL sb_rdata: got %h want %h", rdata, exp);
                    end
                    last_load = exp;
                end
            end
            if (!stall) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: stall still high after 64 cycles, want low");
        end
        @(posedge clk); #1;
        memread = 0; memwrite = 0; dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0;
        #1;
        obs_post_quiet = !dmem.dmem_req && !rdata_valid && !stall;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 0; memread = 1; memwrite = 0; funct3 = F3_W; aluout = 32'h101; regop2 = '0;
        dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = '0;
        #1;
        checks++;
        if ({fault, stall, dmem.dmem_req, rdata_valid} !== 4'b0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bad_req: fault=%b stall=%b req=%b rv=%b rdata=%h want all 0",
                     fault, stall, dmem.dmem_req, rdata_valid, rdata);
        end
        aluout = 32'h100; #1;
        checks++;
        if (stall !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_good_req: stall=%b fault=%b want 0 0", stall, fault);
        end
        memread = 0; aluout = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1; #1;
        checks++;
        if (dmem.dmem_req !== 1'b0 || stall !== 1'b0 || dmem.dmem_be !== 4'b0 ||
            dmem.dmem_addr !== 32'h0 || dmem.dmem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: req=%b stall=%b be=%b addr=%h wdata=%h want zeros",
                     dmem.dmem_req, stall, dmem.dmem_be, dmem.dmem_addr, dmem.dmem_wdata);
        end
    endtask

    task automatic test_lb_sign;
        exp_q.push_back(32'hFFFF_FF80);
        do_access(1, 0, F3_B, 32'h103, '0, 0, 0, 32'h80FF_0000);
        checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_we !== 1'b0) begin
            errors++;
            $display("FAIL lb_bus: addr=%h be=%b we=%b want 100 1111 0", obs_addr, obs_be, obs_we);
        end
        checks++;
        if (obs_stall !== 3) begin
            errors++;
            $display("FAIL lb_stall: got %0d cycles want 3", obs_stall);
        end
        checks++;
        if (obs_rvalid !== 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL lb_rvalid: got %0d pulses (%0d pending) want 1 (0)", obs_rvalid, exp_q.size());
        end
        checks++;
        if (!obs_post_quiet) begin
            errors++;
            $display("FAIL lb_after_resp: bus or stall active after RESP, want idle");
        end
    endtask

    task automatic test_sh_store;
        do_access(0, 1, F3_H, 32'h102, 32'h1234_ABCD, 0, 0, '0);
        checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1) begin
            errors++;
            $display("FAIL sh_bus: addr=%h be=%b wdata=%h we=%b want 100 1100 abcdabcd 1",
                     obs_addr, obs_be, obs_wdata, obs_we);
        end
        checks++;
        if (obs_stall !== 2 || obs_rvalid !== 0) begin
            errors++;
            $display("FAIL sh_timing: stall=%0d rvalid=%0d want 2 0", obs_stall, obs_rvalid);
        end
        checks++;
        if (rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL sh_rdata_hold: got %h want ffffff80", rdata);
        end
    endtask

    task automatic test_lw_misaligned;
        do_access(1, 0, F3_W, 32'h101, '0, 0, 0, '0);
        checks++;
        if (obs_fault_first !== 1'b1 || obs_req !== 0 || obs_stall !== 0) begin
            errors++;
            $display("FAIL lw_misaligned: fault=%b req_cycles=%0d stall=%0d want 1 0 0",
                     obs_fault_first, obs_req, obs_stall);
        end
        checks++;
        if (!obs_post_quiet) begin
            errors++;
            $display("FAIL lw_misaligned_after: bus active after fault, want idle");
        end
    endtask

    task automatic test_illegal;
        logic [1:0]  rw  [9] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        logic [2:0]  f3s [9] = '{F3_W, F3_BU, F3_HU, 3'b011, 3'b011, 3'b110, 3'b111, F3_H, F3_HU};
        logic [31:0] adr [9] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100,
                                 32'h101, 32'h103};
        for (int i = 0; i < 9; i++) begin
            do_access(rw[i][1], rw[i][0], f3s[i], adr[i], 32'h5555_5555, 0, 0, '0);
            checks++;
            if (obs_fault_first !== 1'b1 || obs_req !== 0 || obs_stall !== 0) begin
                errors++;
                $display("FAIL illegal_%0d: fault=%b req_cycles=%0d stall=%0d want 1 0 0",
                         i, obs_fault_first, obs_req, obs_stall);
            end
        end
    endtask

    // gnt is low for four cycles (the accept cycle plus three REQ cycles) and
    // arrives in the fourth REQ cycle.
    task automatic test_store_gnt_wait;
        do_access(0, 1, F3_W, 32'h20C, 32'hCAFE_F00D, 3, 0, '0);
        checks++;
        if (obs_req !== 4 || !obs_payload_stable) begin
            errors++;
            $display("FAIL sw_wait_req: req_cycles=%0d stable=%b want 4 1", obs_req, obs_payload_stable);
        end
        checks++;
        if (obs_stall !== 5) begin
            errors++;
            $display("FAIL sw_wait_stall: got %0d cycles want 5", obs_stall);
        end
        checks++;
        if (obs_addr !== 32'h20C || obs_be !== 4'b1111 || obs_wdata !== 32'hCAFE_F00D || obs_rvalid !== 0) begin
            errors++;
            $display("FAIL sw_wait_bus: addr=%h be=%b wdata=%h rvalid=%0d want 20c 1111 cafef00d 0",
                     obs_addr, obs_be, obs_wdata, obs_rvalid);
        end
    endtask

    task automatic test_lhu;
        exp_q.push_back(32'h0000_8001);
        do_access(1, 0, F3_HU, 32'h102, '0, 0, 0, 32'h8001_0000);
        checks++;
        if (obs_rvalid !== 1 || obs_stall !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL lhu: rvalid=%0d stall=%0d pending=%0d want 1 3 0", obs_rvalid, obs_stall, exp_q.size());
        end
    endtask

    task automatic test_load_lanes;
        logic [2:0] f3s  [8] = '{F3_B, F3_B, F3_BU, F3_BU, F3_H, F3_H, F3_HU, F3_W};
        logic [1:0] offs [8] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w = $urandom() | 32'h8080_8080;
            exp_q.push_back(model_load(f3s[i], offs[i], w));
            do_access(1, 0, f3s[i], {28'h000_0040, 2'(i), offs[i]}, '0, i % 3, i % 2, w);
            checks++;
            if (obs_rvalid !== 1 || obs_stall !== 3 + (i % 3) + (i % 2) || obs_be !== 4'b1111) begin
                errors++;
                $display("FAIL load_lane_%0d: rvalid=%0d stall=%0d be=%b want 1 %0d 1111",
                         i, obs_rvalid, obs_stall, obs_be, 3 + (i % 3) + (i % 2));
            end
        end
    endtask

    task automatic test_stores;
        logic [2:0] f3s  [6] = '{F3_B, F3_B, F3_B, F3_B, F3_H, F3_H};
        logic [1:0] offs [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            d = $urandom();
            do_access(0, 1, f3s[i], {30'h0000_0090, offs[i]}, d, 0, 0, '0);
            checks++;
            if (obs_be !== model_be(f3s[i], offs[i]) || obs_wdata !== model_wdata(f3s[i], d) ||
                obs_addr !== 32'h240) begin
                errors++;
                $display("FAIL store_%0d: be=%b wdata=%h addr=%h want %b %h 240", i, obs_be, obs_wdata,
                         obs_addr, model_be(f3s[i], offs[i]), model_wdata(f3s[i], d));
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(32'hFFFF_8765);
        exp_q.push_back(32'h0000_0011);
        do_access(1, 0, F3_H, 32'h300, '0, 2, 3, 32'h1234_8765);
        do_access(1, 0, F3_BU, 32'h305, '0, 0, 0, 32'hAABB_11CC);
        checks++;
        if (exp_q.size() != 0 || rdata !== 32'h0000_0011) begin
            errors++;
            $display("FAIL back_to_back: pending=%0d rdata=%h want 0 00000011", exp_q.size(), rdata);
        end
    endtask

    task automatic test_reset_in_wait;
        bit any_rv = 0, any_stall = 0, any_req = 0, any_rdata = 0;
        checks++;
        if (rdata !== last_load) begin
            errors++;
            $display("FAIL rdata_hold: got %h want %h", rdata, last_load);
        end
        @(posedge clk); #1;
        memread = 1; memwrite = 0; funct3 = F3_W; aluout = 32'h400;
        @(posedge clk); #1;
        dmem.dmem_gnt = 1;
        @(posedge clk); #1;
        dmem.dmem_gnt = 0; #1;
        checks++;
        if (stall !== 1'b1 || dmem.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: stall=%b req=%b want 1 0", stall, dmem.dmem_req);
        end
        rst_n = 0; #1;
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h0 || rdata_valid !== 1'b0 || dmem.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: stall=%b rdata=%h rv=%b req=%b want 0 0 0 0",
                     stall, rdata, rdata_valid, dmem.dmem_req);
        end
        memread = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            dmem.dmem_rvalid = (c == 0);
            dmem.dmem_rdata  = 32'h1234_5678;
            #1;
            if (rdata_valid) any_rv = 1;
            if (stall) any_stall = 1;
            if (dmem.dmem_req) any_req = 1;
            if (rdata !== 32'h0) any_rdata = 1;
        end
        dmem.dmem_rvalid = 0;
        checks++;
        if (any_rv || any_rdata) begin
            errors++;
            $display("FAIL stray_rvalid: rv_seen=%b rdata_changed=%b want 0 0", any_rv, any_rdata);
        end
        checks++;
        if (any_stall || any_req) begin
            errors++;
            $display("FAIL stray_idle: stall_seen=%b req_seen=%b want 0 0", any_stall, any_req);
        end
    endtask

    initial begin
        last_load = '0;
        test_reset();
        test_lb_sign();
        test_sh_store();
        test_lw_misaligned();
        test_illegal();
        test_store_gnt_wait();
        test_lhu();
        test_load_lanes();
        test_stores();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
